id_ctrl: RTL and testbench
==========================

ID_CTRL -- requirements
Module: id_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: if_valid in 1, if_instr in 32, if_pc in 64 (fetch offer); if_ready out 1 (fetch accept).
REQ-004 SHALL have: id_valid out 1, id_instr out 32, id_pc out 64 (decode-stage issue to EX); id_ready in 1 (EX accept).
REQ-005 SHALL have: ex_valid in 1, ex_is_load in 1, ex_rd in 5 (instruction currently in EX).
REQ-006 SHALL have: pipe_empty in 1 (EX/MEM/WB hold no valid instruction); flush in 1 (redirect from branch/jump resolution).
REQ-007 SHALL have: stall_cnt out 32 (hazard/serialisation stall-cycle counter).

Function
REQ-008 SHALL hold one instruction buffer (instr, pc) plus a state register: EMPTY, FULL, HAZ, CSRW.
REQ-009 SHALL compute fire_in = if_valid & if_ready and fire_out = id_valid & id_ready.
REQ-010 SHALL drive if_ready = !flush & (state==EMPTY | fire_out).
REQ-011 SHALL drive id_valid = !flush & (state==FULL) & !hazard & !csr_wait, combinationally from the current buffer and inputs.
REQ-012 SHALL drive id_instr/id_pc straight from the buffer; contents are don't-care when id_valid=0.
REQ-013 SHALL define rs1_used = 0 for opcodes 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL), and for 1110011 with func3[2]=1; 1 otherwise.
REQ-014 SHALL define rs2_used = 1 only for opcodes 0110011, 0111011, 1100011, 0100011.
REQ-015 SHALL assert hazard when ex_valid & ex_is_load & ex_rd!=0 & ((rs1_used & Rs1==ex_rd) | (rs2_used & Rs2==ex_rd)).
REQ-016 SHALL assert csr_wait when buffered opcode==1110011 & !pipe_empty.
REQ-017 Transitions SHALL be: EMPTY->FULL on fire_in; FULL->HAZ when hazard; FULL->CSRW when csr_wait (hazard takes priority); HAZ/CSRW->FULL once the condition clears; FULL->EMPTY on fire_out without fire_in; FULL stays FULL on simultaneous fire_out and fire_in (buffer replaced, zero bubble).
REQ-018 HAZ/CSRW SHALL be re-evaluated each cycle; id_valid remains 0 in HAZ/CSRW and in the transition cycle back to FULL, i.e. issue occurs the cycle after the condition clears.
REQ-019 flush SHALL take priority over all events: no capture, no issue, and next state=EMPTY.
REQ-020 FULL with id_ready=0 and no hazard SHALL hold the buffer stable and keep id_valid=1.
REQ-021 stall_cnt SHALL increment by 1 each cycle state is HAZ or CSRW and flush=0; it SHALL saturate at 0xFFFF_FFFF.
REQ-022 Latency SHALL be: instruction captured at edge N is offered on id_valid in cycle N+1 when there is no hazard.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=EMPTY, buffer=0, stall_cnt=0; hence if_ready=1 (flush=0), id_valid=0.
REQ-024 Reset asserted mid-stall SHALL discard the buffered instruction without issuing it.

Structure
REQ-025 Opcode constants (LUI, AUIPC, JAL, OP, OP32, BRANCH, STORE, SYSTEM) and the state enum SHALL live in the shared CPU package.
REQ-026 SHALL instantiate the existing decoder module once on the buffered instruction to obtain Rs1, Rs2, opcode, func3; no duplicate field extraction.

Verification
REQ-027 Reset: rst_n=0 mid-cycle -> immediately id_valid=0, if_ready=1, stall_cnt=0.
REQ-028 Streaming: if_valid=1 with id_ready=1, instrs 0x00000013 x3 -> one issued per cycle, 1-cycle latency, no bubbles.
REQ-029 Load-use: buffer 0x00208033 (add x0,x1,x2), ex_valid=1, ex_is_load=1, ex_rd=2 for 1 cycle -> state HAZ, id_valid=0, stall_cnt=1, issue on the following cycle; same test with ex_rd=0 -> no stall.
REQ-030 CSR serialise: buffer 0x30002573 (csrr a0,mstatus), pipe_empty=0 for 3 cycles -> id_valid=0 for 3 cycles, stall_cnt=3, then issues.
REQ-031 Flush: in HAZ, assert flush=1 -> next cycle EMPTY, stalled instr never issued, if_ready=0 during flush cycle.
REQ-032 Backpressure: FULL, id_ready=0 for 4 cycles -> id_instr/id_pc stable, if_ready=0, stall_cnt unchanged.

Source files
------------

// File: rtl/id_ctrl_pkg.sv
// Shared CPU definitions used by the decode-stage issue controller:
// RV opcode constants and the decode buffer state encoding.
package id_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HAZ   = 2'd2,
        ST_CSRW  = 2'd3
    } id_state_e;

    // SYSTEM ops with func3[2] set take a zimm in the rs1 field, not a register.
    function automatic logic uses_rs1(input logic [6:0] opcode, input logic func3_msb);
        return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                 ((opcode == OPC_SYSTEM) && func3_msb));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPC_OP) || (opcode == OPC_OP32) ||
               (opcode == OPC_BRANCH) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/id_ctrl_if.sv
// Fetch-to-decode offer and decode-to-execute issue handshakes.
// The slave modport is the decode controller; master is its environment.
interface id_ctrl_if;

    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        if_ready;

    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic        id_ready;

    modport master (
        output if_valid, if_instr, if_pc, id_ready,
        input  if_ready, id_valid, id_instr, id_pc
    );

    modport slave (
        input  if_valid, if_instr, if_pc, id_ready,
        output if_ready, id_valid, id_instr, id_pc
    );

endinterface

// File: rtl/id_ctrl_decoder.sv
// Field extractor for a 32-bit RV instruction word: the register-source
// operands and major opcode/func3 needed by the hazard logic.
module id_ctrl_decoder (
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    logic unused_fields;

    assign opcode        = instr[6:0];
    assign func3         = instr[14:12];
    assign rs1           = instr[19:15];
    assign rs2           = instr[24:20];
    assign unused_fields = ^{instr[31:25], instr[11:7]};

endmodule

// File: rtl/id_ctrl.sv
// Decode-stage issue controller: one-entry instruction buffer that holds
// back load-use hazards and CSR accesses until the pipeline is ready.
module id_ctrl
    import id_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    id_ctrl_if.slave      bus,
    input  logic          ex_valid,
    input  logic          ex_is_load,
    input  logic [4:0]    ex_rd,
    input  logic          pipe_empty,
    input  logic          flush,
    output logic [31:0]   stall_cnt
);

    id_state_e   state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        unused_func3;

    logic rs1_used, rs2_used;
    logic hazard, csr_wait;
    logic id_valid, if_ready;
    logic fire_in, fire_out;

    id_ctrl_decoder u_decoder (
        .instr  (instr_q),
        .opcode (opcode),
        .func3  (func3),
        .rs1    (rs1),
        .rs2    (rs2)
    );

    assign unused_func3 = ^func3[1:0];

    always_comb begin
        rs1_used = uses_rs1(opcode, func3[2]);
        rs2_used = uses_rs2(opcode);
        hazard   = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                   ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
        csr_wait = (opcode == OPC_SYSTEM) && !pipe_empty;
        id_valid = !flush && (state_q == ST_FULL) && !hazard && !csr_wait;
        fire_out = id_valid && bus.id_ready;
        if_ready = !flush && ((state_q == ST_EMPTY) || fire_out);
        fire_in  = bus.if_valid && if_ready;
    end

    assign bus.id_valid = id_valid;
    assign bus.if_ready = if_ready;
    assign bus.id_instr = instr_q;
    assign bus.id_pc    = pc_q;
    assign stall_cnt    = stall_cnt_q;

    // Flush overrides everything; fire_in is already masked by flush via if_ready.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (fire_in) state_d = ST_FULL;
                ST_FULL: begin
                    if (hazard)                    state_d = ST_HAZ;
                    else if (csr_wait)             state_d = ST_CSRW;
                    else if (fire_out && !fire_in) state_d = ST_EMPTY;
                end
                ST_HAZ:  if (!hazard)   state_d = ST_FULL;
                ST_CSRW: if (!csr_wait) state_d = ST_FULL;
                default: state_d = ST_EMPTY;
            endcase

            if ((state_q == ST_HAZ || state_q == ST_CSRW) && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_d = stall_cnt_q + 32'd1;
        end

        if (fire_in) begin
            instr_d = bus.if_instr;
            pc_d    = bus.if_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            instr_q     <= 32'd0;
            pc_q        <= 64'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_ctrl.sv
// Directed, table-driven bench for id_ctrl: each row is one clock cycle of
// inputs with the outputs expected during that cycle.
module tb_id_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADD  = 32'h0020_8033;
    localparam logic [31:0] LUI5 = 32'h0002_80B7;
    localparam logic [31:0] CSRR = 32'h3000_2573;
    localparam logic [31:0] ADDI = 32'h0010_0093;

    typedef struct {
        logic        if_valid;
        logic [31:0] if_instr;
        logic [63:0] if_pc;
        logic        id_ready;
        logic        ex_valid;
        logic        ex_is_load;
        logic [4:0]  ex_rd;
        logic        pipe_empty;
        logic        flush;
        logic        e_if_ready;
        logic        e_id_valid;
        logic [31:0] e_id_instr;
        logic [63:0] e_id_pc;
        logic [31:0] e_stall;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        pipe_empty;
    logic        flush;
    logic [31:0] stall_cnt;

    int   n_vec;
    int   n_miss;
    vec_t vecs[$];

    id_ctrl_if bus_if();

    id_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .pipe_empty (pipe_empty),
        .flush      (flush),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int iv, input logic [31:0] ins, input logic [63:0] pc,
                                input int ird, input int exv, input int exl, input int exrd,
                                input int pe, input int fl, input int eir, input int eiv,
                                input logic [31:0] eins, input logic [63:0] epc, input int est);
        vec_t v;
        v.if_valid   = (iv != 0);
        v.if_instr   = ins;
        v.if_pc      = pc;
        v.id_ready   = (ird != 0);
        v.ex_valid   = (exv != 0);
        v.ex_is_load = (exl != 0);
        v.ex_rd      = 5'(exrd);
        v.pipe_empty = (pe != 0);
        v.flush      = (fl != 0);
        v.e_if_ready = (eir != 0);
        v.e_id_valid = (eiv != 0);
        v.e_id_instr = eins;
        v.e_id_pc    = epc;
        v.e_stall    = 32'(est);
        return v;
    endfunction

    // Idle cycle: nothing offered, EX ready, pipeline empty.
    function automatic vec_t idle(input int eir, input int eiv, input logic [31:0] eins,
                                  input logic [63:0] epc, input int est);
        return mk(0, 32'h0, 64'h0, 1, 0, 0, 0, 1, 0, eir, eiv, eins, epc, est);
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus_if.if_valid = v.if_valid;
        bus_if.if_instr = v.if_instr;
        bus_if.if_pc    = v.if_pc;
        bus_if.id_ready = v.id_ready;
        ex_valid        = v.ex_valid;
        ex_is_load      = v.ex_is_load;
        ex_rd           = v.ex_rd;
        pipe_empty      = v.pipe_empty;
        flush           = v.flush;
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        n_vec++;
        cmp({tag, ".if_ready"},  64'(bus_if.if_ready), 64'(v.e_if_ready));
        cmp({tag, ".id_valid"},  64'(bus_if.id_valid), 64'(v.e_id_valid));
        cmp({tag, ".stall_cnt"}, 64'(stall_cnt),       64'(v.e_stall));
        if (v.e_id_valid) begin
            cmp({tag, ".id_instr"}, 64'(bus_if.id_instr), 64'(v.e_id_instr));
            cmp({tag, ".id_pc"},    bus_if.id_pc,         v.e_id_pc);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        rst_n           = 1'b0;
        bus_if.if_valid = 1'b0;
        bus_if.if_instr = 32'h0;
        bus_if.if_pc    = 64'h0;
        bus_if.id_ready = 1'b1;
        ex_valid        = 1'b0;
        ex_is_load      = 1'b0;
        ex_rd           = 5'd0;
        pipe_empty      = 1'b1;
        flush           = 1'b0;

        // Streaming: one NOP per cycle, 1-cycle latency, no bubbles
        vecs.push_back(mk(1, NOP, 64'h1000, 1, 0, 0, 0, 1, 0,  1, 0, 32'h0, 64'h0,    0));
        vecs.push_back(mk(1, NOP, 64'h1004, 1, 0, 0, 0, 1, 0,  1, 1, NOP,   64'h1000, 0));
        vecs.push_back(mk(1, NOP, 64'h1008, 1, 0, 0, 0, 1, 0,  1, 1, NOP,   64'h1004, 0));
        vecs.push_back(idle(1, 1, NOP, 64'h1008, 0));
        vecs.push_back(idle(1, 0, 32'h0, 64'h0, 0));
        // CSR serialise: pipe_empty low for 3 cycles
        vecs.push_back(mk(1, CSRR, 64'h4000, 1, 0, 0, 0, 1, 0,  1, 0, 32'h0, 64'h0, 0));
        vecs.push_back(mk(0, 32'h0, 64'h0, 1, 0, 0, 0, 0, 0,    0, 0, 32'h0, 64'h0, 0));
        vecs.push_back(mk(0, 32'h0, 64'h0, 1, 0, 0, 0, 0, 0,    0, 0, 32'h0, 64'h0, 0));
        vecs.push_back(mk(0, 32'h0, 64'h0, 1, 0, 0, 0, 0, 0,    0, 0, 32'h0, 64'h0, 1));
        vecs.push_back(idle(0, 0, 32'h0, 64'h0, 2));
        vecs.push_back(idle(1, 1, CSRR, 64'h4000, 3));
        // Backpressure: FULL with id_ready low for 4 cycles
        vecs.push_back(mk(1, NOP, 64'h3000, 0, 0, 0, 0, 1, 0,  1, 0, 32'h0, 64'h0, 3));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1, ADDI, 64'h3004, 0, 0, 0, 0, 1, 0,  0, 1, NOP, 64'h3000, 3));
        vecs.push_back(idle(1, 1, NOP, 64'h3000, 3));
        // Load-use on rs2, then ex_rd=0, rs1-unused LUI, non-load producer, rs1 hazard
        vecs.push_back(mk(1, ADD, 64'h2000, 1, 0, 0, 0, 1, 0,  1, 0, 32'h0, 64'h0,    3));
        vecs.push_back(mk(0, 32'h0, 64'h0,  1, 1, 1, 2, 1, 0,  0, 0, 32'h0, 64'h0,    3));
        vecs.push_back(idle(0, 0, 32'h0, 64'h0, 3));
        vecs.push_back(idle(1, 1, ADD, 64'h2000, 4));
        vecs.push_back(mk(1, ADD, 64'h2100, 1, 0, 0, 0, 1, 0,  1, 0, 32'h0, 64'h0,    4));
        vecs.push_back(mk(0, 32'h0, 64'h0,  1, 1, 1, 0, 1, 0,  1, 1, ADD,   64'h2100, 4));
        vecs.push_back(mk(1, LUI5, 64'h2200, 1, 0, 0, 0, 1, 0, 1, 0, 32'h0, 64'h0,    4));
        vecs.push_back(mk(0, 32'h0, 64'h0,  1, 1, 1, 5, 1, 0,  1, 1, LUI5,  64'h2200, 4));
        vecs.push_back(mk(1, ADD, 64'h2300, 1, 0, 0, 0, 1, 0,  1, 0, 32'h0, 64'h0,    4));
        vecs.push_back(mk(0, 32'h0, 64'h0,  1, 1, 0, 1, 1, 0,  1, 1, ADD,   64'h2300, 4));
        vecs.push_back(mk(1, ADD, 64'h2400, 1, 0, 0, 0, 1, 0,  1, 0, 32'h0, 64'h0,    4));
        vecs.push_back(mk(0, 32'h0, 64'h0,  1, 1, 1, 1, 1, 0,  0, 0, 32'h0, 64'h0,    4));
        vecs.push_back(idle(0, 0, 32'h0, 64'h0, 4));
        vecs.push_back(idle(1, 1, ADD, 64'h2400, 5));
        // Flush while in HAZ, in EMPTY with an offer, and in FULL
        vecs.push_back(mk(1, ADD, 64'h2500, 1, 0, 0, 0, 1, 0,  1, 0, 32'h0, 64'h0, 5));
        vecs.push_back(mk(0, 32'h0, 64'h0,  1, 1, 1, 2, 1, 0,  0, 0, 32'h0, 64'h0, 5));
        vecs.push_back(mk(0, 32'h0, 64'h0,  1, 1, 1, 2, 1, 0,  0, 0, 32'h0, 64'h0, 5));
        vecs.push_back(mk(0, 32'h0, 64'h0,  1, 1, 1, 2, 1, 1,  0, 0, 32'h0, 64'h0, 6));
        vecs.push_back(idle(1, 0, 32'h0, 64'h0, 6));
        vecs.push_back(idle(1, 0, 32'h0, 64'h0, 6));
        vecs.push_back(mk(1, NOP, 64'h5000, 1, 0, 0, 0, 1, 1,  0, 0, 32'h0, 64'h0, 6));
        vecs.push_back(idle(1, 0, 32'h0, 64'h0, 6));
        vecs.push_back(mk(1, NOP, 64'h5100, 1, 0, 0, 0, 1, 0,  1, 0, 32'h0, 64'h0, 6));
        vecs.push_back(mk(0, 32'h0, 64'h0,  1, 0, 0, 0, 1, 1,  0, 0, 32'h0, 64'h0, 6));
        vecs.push_back(idle(1, 0, 32'h0, 64'h0, 6));

        #7;
        checkOutput(idle(1, 0, 32'h0, 64'h0, 0), "reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("v%0d", i));
        end

        // Reset asserted mid-cycle while stalled on a load-use hazard
        applyStimulus(mk(1, ADD, 64'h6000, 1, 0, 0, 0, 1, 0,  1, 0, 32'h0, 64'h0, 6));
        checkOutput(mk(1, ADD, 64'h6000, 1, 0, 0, 0, 1, 0,  1, 0, 32'h0, 64'h0, 6), "rst.fill");
        applyStimulus(mk(0, 32'h0, 64'h0, 1, 1, 1, 2, 1, 0,  0, 0, 32'h0, 64'h0, 6));
        checkOutput(mk(0, 32'h0, 64'h0, 1, 1, 1, 2, 1, 0,  0, 0, 32'h0, 64'h0, 6), "rst.haz");
        applyStimulus(mk(0, 32'h0, 64'h0, 1, 1, 1, 2, 1, 0,  0, 0, 32'h0, 64'h0, 6));
        checkOutput(mk(0, 32'h0, 64'h0, 1, 1, 1, 2, 1, 0,  0, 0, 32'h0, 64'h0, 6), "rst.stall");
        applyStimulus(mk(0, 32'h0, 64'h0, 1, 1, 1, 2, 1, 0,  0, 0, 32'h0, 64'h0, 7));
        checkOutput(mk(0, 32'h0, 64'h0, 1, 1, 1, 2, 1, 0,  0, 0, 32'h0, 64'h0, 7), "rst.pre");
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput(idle(1, 0, 32'h0, 64'h0, 0), "rst.async");
        @(negedge clk);
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
        ex_rd      = 5'd0;
        rst_n      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(idle(1, 0, 32'h0, 64'h0, 0));
            checkOutput(idle(1, 0, 32'h0, 64'h0, 0), $sformatf("rst.post%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
